// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: host-transmit FSM states, protocol timing defaults and keyboard command bytes.
// Timing defaults are given in microseconds and converted to clock cycles for a given clock frequency.
package ps2_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_INHIBIT,
        ST_REQUEST,
        ST_DATA,
        ST_PARITY,
        ST_STOP,
        ST_ACK,
        ST_FINISH
    } ps2_tx_state_t;

    localparam int unsigned PS2_DEF_CLK_HZ  = 50_000_000;
    localparam int unsigned PS2_INHIBIT_US  = 100;
    localparam int unsigned PS2_TIMEOUT_US  = 15_000;

    localparam logic [7:0] PS2_CMD_SET_LEDS = 8'hED;
    localparam logic [7:0] PS2_CMD_RESET    = 8'hFF;
    localparam logic [7:0] PS2_CMD_ENABLE   = 8'hF4;

    // 64-bit intermediate: 50 MHz * 15000 us overflows 32 bits.
    function automatic int unsigned ps2_us_to_cycles(input int unsigned clk_hz, input int unsigned us);
        logic [63:0] w_cyc;
        w_cyc = (64'(clk_hz) * 64'(us)) / 64'd1_000_000;
        return 32'(w_cyc);
    endfunction

    localparam int unsigned PS2_DEF_INHIBIT_CYCLES = ps2_us_to_cycles(PS2_DEF_CLK_HZ, PS2_INHIBIT_US);
    localparam int unsigned PS2_DEF_TIMEOUT_CYCLES = ps2_us_to_cycles(PS2_DEF_CLK_HZ, PS2_TIMEOUT_US);

endpackage

// File: rtl/ps2_sync_edge.sv
// Two-flop synchronizers for PS/2 clock and data pads plus device-clock falling-edge strobe.
// Idle level of both lines is high, so the flops reset to 1 and no edge is seen out of reset.
module ps2_sync_edge (
    input  logic clk,
    input  logic rst,
    input  logic i_ps2_clk,
    input  logic i_ps2_dat,
    output logic o_clk_sync,
    output logic o_dat_sync,
    output logic o_clk_fall
);

    logic r_clk_meta;
    logic r_clk_sync;
    logic r_clk_prev;
    logic r_dat_meta;
    logic r_dat_sync;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_clk_meta <= 1'b1;
            r_clk_sync <= 1'b1;
            r_clk_prev <= 1'b1;
            r_dat_meta <= 1'b1;
            r_dat_sync <= 1'b1;
        end else begin
            r_clk_meta <= i_ps2_clk;
            r_clk_sync <= r_clk_meta;
            r_clk_prev <= r_clk_sync;
            r_dat_meta <= i_ps2_dat;
            r_dat_sync <= r_dat_meta;
        end
    end

    assign o_clk_sync = r_clk_sync;
    assign o_dat_sync = r_dat_sync;
    assign o_clk_fall = r_clk_prev & ~r_clk_sync;

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device byte transmitter: inhibit, request-to-send, 8 data bits + odd parity + stop, device ACK check.
// tx_ready is high only in IDLE; a tx_valid seen while busy is dropped, never queued.
module ps2_host_tx
    import ps2_pkg::*;
#(
    parameter int unsigned CLK_HZ         = PS2_DEF_CLK_HZ,
    parameter int unsigned INHIBIT_CYCLES = ps2_us_to_cycles(CLK_HZ, PS2_INHIBIT_US),
    parameter int unsigned TIMEOUT_CYCLES = ps2_us_to_cycles(CLK_HZ, PS2_TIMEOUT_US)
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tx_valid,
    input  logic [7:0] tx_data,
    output logic       tx_ready,
    output logic       tx_done,
    output logic       tx_err,
    input  logic       ps2_clk_in,
    input  logic       ps2_dat_in,
    output logic       ps2_clk_oe,
    output logic       ps2_dat_oe,
    inout  wire        ps2_clk_pad,
    inout  wire        ps2_dat_pad
);

    localparam int INH_W = $clog2(INHIBIT_CYCLES) + 1;
    localparam int TO_W  = $clog2(TIMEOUT_CYCLES) + 1;

    ps2_tx_state_t r_state;
    ps2_tx_state_t w_state_nxt;

    logic [INH_W-1:0] r_inh_cnt;
    logic [TO_W-1:0]  r_to_cnt;
    logic [2:0]       r_bit_idx;
    logic [7:0]       r_data;
    logic             r_parity;
    logic             r_dat_oe;
    logic             r_req_first;

    logic w_clk_sync;
    logic w_dat_sync;
    logic w_fall;
    logic w_active;
    logic w_enter_req;
    logic w_timeout;
    logic w_done;
    logic w_nack;

    ps2_sync_edge u_sync (
        .clk        (clk),
        .rst        (rst),
        .i_ps2_clk  (ps2_clk_in),
        .i_ps2_dat  (ps2_dat_in),
        .o_clk_sync (w_clk_sync),
        .o_dat_sync (w_dat_sync),
        .o_clk_fall (w_fall)
    );

    assign w_active    = (r_state != ST_IDLE) && (r_state != ST_INHIBIT);
    assign w_enter_req = (r_state == ST_INHIBIT) && (w_state_nxt == ST_REQUEST);
    // A falling edge in the very cycle the limit is reached counts as progress, not a timeout.
    assign w_timeout   = w_active && !w_fall && (r_to_cnt == TO_W'(TIMEOUT_CYCLES - 1));

    always_comb begin
        w_state_nxt = r_state;
        w_done      = 1'b0;
        w_nack      = 1'b0;
        unique case (r_state)
            ST_IDLE:    if (tx_valid) w_state_nxt = ST_INHIBIT;
            ST_INHIBIT: if (r_inh_cnt == INH_W'(INHIBIT_CYCLES - 1)) w_state_nxt = ST_REQUEST;
            ST_REQUEST: if (w_fall) w_state_nxt = ST_DATA;
            ST_DATA:    if (w_fall && r_bit_idx == 3'd7) w_state_nxt = ST_PARITY;
            ST_PARITY:  if (w_fall) w_state_nxt = ST_STOP;
            ST_STOP:    if (w_fall) w_state_nxt = ST_ACK;
            ST_ACK: begin
                if (w_fall) begin
                    if (!w_dat_sync) begin
                        w_state_nxt = ST_FINISH;
                    end else begin
                        w_state_nxt = ST_IDLE;
                        w_nack      = 1'b1;
                    end
                end
            end
            ST_FINISH: begin
                if (w_clk_sync && w_dat_sync) begin
                    w_state_nxt = ST_IDLE;
                    w_done      = 1'b1;
                end
            end
            default:    w_state_nxt = ST_IDLE;
        endcase
        if (w_timeout) begin
            w_state_nxt = ST_IDLE;
            w_done      = 1'b0;
            w_nack      = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state     <= ST_IDLE;
            r_inh_cnt   <= '0;
            r_to_cnt    <= '0;
            r_bit_idx   <= 3'd0;
            r_data      <= 8'd0;
            r_parity    <= 1'b0;
            r_dat_oe    <= 1'b0;
            r_req_first <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_req_first <= w_enter_req;

            if (r_state == ST_IDLE && tx_valid) begin
                r_data   <= tx_data;
                r_parity <= ~^tx_data;
            end

            r_inh_cnt <= (r_state == ST_INHIBIT) ? r_inh_cnt + 1'b1 : '0;

            if (w_enter_req || w_fall || !w_active) begin
                r_to_cnt <= '0;
            end else begin
                r_to_cnt <= r_to_cnt + 1'b1;
            end

            if (w_state_nxt == ST_IDLE) begin
                r_dat_oe  <= 1'b0;
            end else if (w_enter_req) begin
                r_dat_oe  <= 1'b1;
                r_bit_idx <= 3'd0;
            end else if (w_fall) begin
                // oe is the inverse of the bit: driving low sends 0, releasing lets the pull-up send 1.
                case (r_state)
                    ST_DATA: begin
                        r_dat_oe <= ~r_data[r_bit_idx];
                        if (r_bit_idx != 3'd7) r_bit_idx <= r_bit_idx + 3'd1;
                    end
                    ST_PARITY: r_dat_oe <= ~r_parity;
                    ST_STOP:   r_dat_oe <= 1'b0;
                    default:   r_dat_oe <= r_dat_oe;
                endcase
            end
        end
    end

    assign tx_ready   = (r_state == ST_IDLE);
    assign tx_done    = rst & w_done;
    assign tx_err     = rst & (w_timeout | w_nack);
    assign ps2_clk_oe = (r_state == ST_INHIBIT) || (r_state == ST_REQUEST && r_req_first);
    assign ps2_dat_oe = r_dat_oe;

    assign ps2_clk_pad = ps2_clk_oe ? 1'b0 : 1'bz;
    assign ps2_dat_pad = ps2_dat_oe ? 1'b0 : 1'bz;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: a clocking PS/2 device model records the frame it samples on rising edges,
// compared against a frame built from the byte arithmetically; pulse/ready/oe behaviour is tallied by a monitor.
module tb_ps2_host_tx;
    import ps2_pkg::*;

    localparam int unsigned CLK_HZ = 1_000_000;
    localparam int INH  = 100;
    localparam int TOUT = 1500;
    localparam int HALF = 40;   // 12.5 kHz device clock at 1 MHz

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       tx_valid = 1'b0;
    logic [7:0] tx_data = 8'd0;
    logic       tx_ready, tx_done, tx_err;
    logic       ps2_clk_in, ps2_dat_in, ps2_clk_oe, ps2_dat_oe;
    wire        ps2_clk_pad, ps2_dat_pad;

    logic dev_clk = 1'b1;
    logic dev_dat = 1'b1;
    bit   dev_abort = 1'b0;
    int   dev_falls = 0;

    int total = 0;
    int bad   = 0;

    int  n_done = 0, n_err = 0, n_both = 0, n_clk_oe = 0, n_overlap = 0, n_rdy_bad = 0;
    bit  busy = 1'b0;

    always #5 clk = ~clk;

    assign ps2_clk_in = dev_clk & ~ps2_clk_oe;
    assign ps2_dat_in = dev_dat & ~ps2_dat_oe;

    ps2_host_tx #(
        .CLK_HZ         (CLK_HZ),
        .INHIBIT_CYCLES (INH),
        .TIMEOUT_CYCLES (TOUT)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .tx_valid    (tx_valid),
        .tx_data     (tx_data),
        .tx_ready    (tx_ready),
        .tx_done     (tx_done),
        .tx_err      (tx_err),
        .ps2_clk_in  (ps2_clk_in),
        .ps2_dat_in  (ps2_dat_in),
        .ps2_clk_oe  (ps2_clk_oe),
        .ps2_dat_oe  (ps2_dat_oe),
        .ps2_clk_pad (ps2_clk_pad),
        .ps2_dat_pad (ps2_dat_pad)
    );

    always @(negedge clk) begin
        if (tx_done) n_done <= n_done + 1;
        if (tx_err) n_err <= n_err + 1;
        if (tx_done && tx_err) n_both <= n_both + 1;
        if (ps2_clk_oe) n_clk_oe <= n_clk_oe + 1;
        if (ps2_clk_oe && ps2_dat_oe) n_overlap <= n_overlap + 1;
        if (rst && (busy == tx_ready)) n_rdy_bad <= n_rdy_bad + 1;
        if (!rst) busy <= 1'b0;
        else if (tx_valid && tx_ready) busy <= 1'b1;
        else if (tx_done || tx_err) busy <= 1'b0;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Start bit, data LSB first, odd parity, stop bit.
    function automatic logic [10:0] model_frame(input logic [7:0] d);
        logic [10:0] f;
        int ones;
        ones = 0;
        f[0] = 1'b0;
        for (int i = 0; i < 8; i++) begin
            f[i+1] = ((d >> i) & 8'd1) != 0;
            ones += ((d >> i) & 8'd1) != 0 ? 1 : 0;
        end
        f[9]  = (ones % 2) == 0;
        f[10] = 1'b1;
        return f;
    endfunction

    task automatic send_byte(input logic [7:0] d);
        int n;
        n = 0;
        while (!tx_ready && n < 5000) begin
            wait_cycles(1);
            n++;
        end
        tx_data  = d;
        tx_valid = 1'b1;
        wait_cycles(1);
        tx_valid = 1'b0;
    endtask

    task automatic device_run(input bit ack, output logic [10:0] frame, output bit seen_req);
        int n;
        frame    = '1;
        n        = 0;
        while (n < INH + 200 && !(ps2_dat_oe && !ps2_clk_oe)) begin
            wait_cycles(1);
            n++;
        end
        seen_req = ps2_dat_oe && !ps2_clk_oe;
        if (seen_req) begin
            wait_cycles(20);
            for (int k = 0; k < 12; k++) begin
                if (dev_abort) break;
                if (k == 11 && ack) dev_dat = 1'b0;
                dev_clk = 1'b0;
                dev_falls++;
                wait_cycles(HALF);
                dev_clk = 1'b1;
                if (k < 11) frame[k] = ps2_dat_in;
                wait_cycles(HALF);
            end
        end
        dev_dat = 1'b1;
        dev_clk = 1'b1;
    endtask

    task automatic run_xfer(input logic [7:0] d, input bit ack, input string tag);
        logic [10:0] fr;
        bit seen;
        int d0, e0, c0, o0, r0, b0;
        d0 = n_done; e0 = n_err; c0 = n_clk_oe; o0 = n_overlap; r0 = n_rdy_bad; b0 = n_both;
        fork
            send_byte(d);
            device_run(ack, fr, seen);
        join
        wait_cycles(5);
        check({tag, "_request_seen"}, 32'(seen), 32'd1);
        check({tag, "_frame"}, 32'(fr), 32'(model_frame(d)));
        check({tag, "_done_pulses"}, 32'(n_done - d0), ack ? 32'd1 : 32'd0);
        check({tag, "_err_pulses"}, 32'(n_err - e0), ack ? 32'd0 : 32'd1);
        check({tag, "_clk_hold_cycles"}, 32'(n_clk_oe - c0), 32'(INH + 1));
        check({tag, "_request_overlap"}, 32'(n_overlap - o0), 32'd1);
        check({tag, "_ready_window"}, 32'(n_rdy_bad - r0), 32'd0);
        check({tag, "_done_err_same_cycle"}, 32'(n_both - b0), 32'd0);
        check({tag, "_idle_oe"}, {30'd0, ps2_clk_oe, ps2_dat_oe}, 32'd0);
    endtask

    initial begin
        logic [10:0] fr;
        bit seen;
        int n, d0, e0, c0, f0;
        logic [7:0] rb;

        // Reset state on the first reset edge
        rst = 1'b0;
        wait_cycles(1);
        check("rst_ready", 32'(tx_ready), 32'd1);
        check("rst_done", 32'(tx_done), 32'd0);
        check("rst_err", 32'(tx_err), 32'd0);
        check("rst_clk_oe", 32'(ps2_clk_oe), 32'd0);
        check("rst_dat_oe", 32'(ps2_dat_oe), 32'd0);
        wait_cycles(2);
        rst = 1'b1;
        wait_cycles(3);

        // Directed bytes with ACK
        run_xfer(PS2_CMD_SET_LEDS, 1'b1, "ed");
        run_xfer(8'h07, 1'b1, "x07");

        // Random bytes
        for (int i = 0; i < 3; i++) begin
            rb = 8'($urandom_range(0, 255));
            run_xfer(rb, 1'b1, $sformatf("rand%0d", i));
        end

        // Missing ACK
        run_xfer(8'hA5, 1'b0, "nack");
        check("nack_ready_after", 32'(tx_ready), 32'd1);

        // Device never clocks: timeout
        d0 = n_done; e0 = n_err;
        send_byte(8'h3C);
        n = 0;
        while (!tx_err && n < INH + TOUT + 50) begin
            wait_cycles(1);
            n++;
        end
        check("timeout_latency",
              (n >= INH + 1 + TOUT - 2 && n <= INH + 1 + TOUT + 2) ? 32'(INH + 1 + TOUT) : 32'(n),
              32'(INH + 1 + TOUT));
        wait_cycles(1);
        check("timeout_oe", {30'd0, ps2_clk_oe, ps2_dat_oe}, 32'd0);
        check("timeout_ready", 32'(tx_ready), 32'd1);
        check("timeout_err_pulses", 32'(n_err - e0), 32'd1);
        check("timeout_done_pulses", 32'(n_done - d0), 32'd0);

        // Reset while data bit 4 is on the wire
        d0 = n_done; e0 = n_err; f0 = dev_falls;
        fork
            device_run(1'b1, fr, seen);
            begin
                send_byte(8'h5A);
                n = 0;
                while (dev_falls - f0 < 6 && n < 3000) begin
                    wait_cycles(1);
                    n++;
                end
                wait_cycles(10);
                rst = 1'b0;
                wait_cycles(1);
                check("midrst_oe", {30'd0, ps2_clk_oe, ps2_dat_oe}, 32'd0);
                check("midrst_ready", 32'(tx_ready), 32'd1);
                check("midrst_pulses", {30'd0, tx_done, tx_err}, 32'd0);
                rst = 1'b1;
                dev_abort = 1'b1;
            end
        join
        dev_abort = 1'b0;
        wait_cycles(50);
        check("midrst_no_done", 32'(n_done - d0), 32'd0);
        check("midrst_no_err", 32'(n_err - e0), 32'd0);
        run_xfer(PS2_CMD_ENABLE, 1'b1, "f4");

        // Second request during a transfer is dropped
        d0 = n_done; c0 = n_clk_oe;
        fork
            device_run(1'b1, fr, seen);
            begin
                send_byte(PS2_CMD_SET_LEDS);
                wait_cycles(300);
                tx_data  = PS2_CMD_RESET;
                tx_valid = 1'b1;
                wait_cycles(5);
                tx_valid = 1'b0;
            end
        join
        wait_cycles(INH + 50);
        check("ignore_frame", 32'(fr), 32'(model_frame(PS2_CMD_SET_LEDS)));
        check("ignore_done_pulses", 32'(n_done - d0), 32'd1);
        check("ignore_no_second_xfer", 32'(n_clk_oe - c0), 32'(INH + 1));
        check("ignore_ready", 32'(tx_ready), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
